// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise pops return registered data.
module sync_fifo_param #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_write_ctrl,
  input  logic [DATA_W-1:0]          in_write_data,
  input  logic                       in_read_ctrl,
  input  logic                       in_clear_err,
  output logic [DATA_W-1:0]          out_read_data,
  output logic                       out_read_valid,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic                       out_is_full,
  output logic                       out_is_empty,
  output logic                       out_almost_full,
  output logic                       out_almost_empty,
  output logic                       out_overflow,
  output logic                       out_underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              rd_acc, wr_acc;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_acc = in_read_ctrl && !empty_q;
  assign wr_acc = in_write_ctrl && (!full_q || rd_acc);

  always_comb begin
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_W'(AFULL_THRESH));
    aempty_d = (count_d <= CNT_W'(AEMPTY_THRESH));
    // A fresh error wins over a clear issued in the same cycle.
    ovf_d    = (in_write_ctrl && !wr_acc) ? 1'b1 : (in_clear_err ? 1'b0 : ovf_q);
    udf_d    = (in_read_ctrl && !rd_acc)  ? 1'b1 : (in_clear_err ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= in_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero when nothing is held.
  assign out_read_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign out_read_valid = !empty_q;
`else
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rd_acc ? mem_q[rd_ptr_q] : rdata_q;
    rvalid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign out_read_data  = rdata_q;
  assign out_read_valid = rvalid_q;
`endif

  assign out_count        = count_q;
  assign out_is_full      = full_q;
  assign out_is_empty     = empty_q;
  assign out_almost_full  = afull_q;
  assign out_almost_empty = aempty_q;
  assign out_overflow     = ovf_q;
  assign out_underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed vector table, hand sequences and random traffic
// on a DEPTH=4 and a DEPTH=3 instance, both checked against a circular-buffer model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_c, rd_c, clr_c;
  logic [7:0] wr_d;

  logic [7:0] o4_rdata, o3_rdata;
  logic       o4_valid, o3_valid;
  logic [2:0] o4_count;
  logic [1:0] o3_count;
  logic       o4_full, o4_empty, o4_af, o4_ae, o4_ovf, o4_udf;
  logic       o3_full, o3_empty, o3_af, o3_ae, o3_ovf, o3_udf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_write_ctrl(wr_c), .in_write_data(wr_d),
    .in_read_ctrl(rd_c), .in_clear_err(clr_c),
    .out_read_data(o4_rdata), .out_read_valid(o4_valid), .out_count(o4_count),
    .out_is_full(o4_full), .out_is_empty(o4_empty), .out_almost_full(o4_af),
    .out_almost_empty(o4_ae), .out_overflow(o4_ovf), .out_underflow(o4_udf));

  sync_fifo_param #(.DATA_W(8), .DEPTH(3), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_write_ctrl(wr_c), .in_write_data(wr_d),
    .in_read_ctrl(rd_c), .in_clear_err(clr_c),
    .out_read_data(o3_rdata), .out_read_valid(o3_valid), .out_count(o3_count),
    .out_is_full(o3_full), .out_is_empty(o3_empty), .out_almost_full(o3_af),
    .out_almost_empty(o3_ae), .out_overflow(o3_ovf), .out_underflow(o3_udf));

  // Reference model: circular buffer described by head index and occupancy.
  int         m_depth [2] = '{4, 3};
  int         m_afth  [2] = '{3, 2};
  int         m_size  [2];
  int         m_head  [2];
  logic [7:0] m_buf   [2][8];
  logic [7:0] m_rd    [2];
  logic       m_val   [2];
  logic       m_ovf   [2];
  logic       m_udf   [2];

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit racc, wacc;
    if (rst) begin
      m_size[k] = 0; m_head[k] = 0; m_rd[k] = 8'h00;
      m_val[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
    end else begin
      racc = rd_c && (m_size[k] > 0);
      wacc = wr_c && ((m_size[k] < m_depth[k]) || racc);
      m_val[k] = racc;
      if (racc) begin
        m_rd[k]   = m_buf[k][m_head[k]];
        m_head[k] = (m_head[k] + 1) % m_depth[k];
        m_size[k] = m_size[k] - 1;
      end
      if (wacc) begin
        m_buf[k][(m_head[k] + m_size[k]) % m_depth[k]] = wr_d;
        m_size[k] = m_size[k] + 1;
      end
      m_ovf[k] = (wr_c && !wacc) ? 1'b1 : (clr_c ? 1'b0 : m_ovf[k]);
      m_udf[k] = (rd_c && !racc) ? 1'b1 : (clr_c ? 1'b0 : m_udf[k]);
    end
  endtask

  task automatic model_check(input int k, input int cnt, input logic v, input logic [7:0] d,
                             input logic f, input logic e, input logic af, input logic ae,
                             input logic ov, input logic ud);
    int         sz;
    logic       ev;
    logic [7:0] ed;
    sz = m_size[k];
`ifdef FIFO_FWFT_EN
    ev = (sz > 0);
    ed = (sz > 0) ? m_buf[k][m_head[k]] : 8'h00;
`else
    ev = m_val[k];
    ed = m_rd[k];
`endif
    cmp($sformatf("d%0d_count", k), cnt, sz);
    cmp($sformatf("d%0d_valid", k), int'(v), int'(ev));
    cmp($sformatf("d%0d_rdata", k), int'(d), int'(ed));
    cmp($sformatf("d%0d_full", k), int'(f), int'(sz == m_depth[k]));
    cmp($sformatf("d%0d_empty", k), int'(e), int'(sz == 0));
    cmp($sformatf("d%0d_afull", k), int'(af), int'(sz >= m_afth[k]));
    cmp($sformatf("d%0d_aempty", k), int'(ae), int'(sz <= 1));
    cmp($sformatf("d%0d_ovf", k), int'(ov), int'(m_ovf[k]));
    cmp($sformatf("d%0d_udf", k), int'(ud), int'(m_udf[k]));
  endtask

  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd,
                       input logic clr, input logic r);
    wr_c = wr; wr_d = d; rd_c = rd; clr_c = clr; rst = r;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    model_check(0, int'(o4_count), o4_valid, o4_rdata, o4_full, o4_empty, o4_af, o4_ae, o4_ovf, o4_udf);
    model_check(1, int'(o3_count), o3_valid, o3_rdata, o3_full, o3_empty, o3_af, o3_ae, o3_ovf, o3_udf);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    logic       r;
    int         cnt;
    logic       v;
    logic [7:0] rdat;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl [24];

  initial begin
    wr_c = 1'b0; wr_d = 8'h00; rd_c = 1'b0; clr_c = 1'b0; rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_size[k] = 0; m_head[k] = 0; m_rd[k] = 8'h00;
      m_val[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
    end

    //           wr    data   rd    clr   rst   cnt  v     rdata  ovf   udf
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 4, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b1, 8'h22, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h44, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h44, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h66, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h66, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h77, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h77, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h77, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h77, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 2, 1'b0, 8'h77, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h77, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h5A, 1'b0, 1'b0};

    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr, tbl[i].r);
      cmp($sformatf("vec%0d_count", i), int'(o4_count), tbl[i].cnt);
      cmp($sformatf("vec%0d_full", i), int'(o4_full), int'(tbl[i].cnt == 4));
      cmp($sformatf("vec%0d_empty", i), int'(o4_empty), int'(tbl[i].cnt == 0));
      cmp($sformatf("vec%0d_afull", i), int'(o4_af), int'(tbl[i].cnt >= 3));
      cmp($sformatf("vec%0d_aempty", i), int'(o4_ae), int'(tbl[i].cnt <= 1));
      cmp($sformatf("vec%0d_ovf", i), int'(o4_ovf), int'(tbl[i].ovf));
      cmp($sformatf("vec%0d_udf", i), int'(o4_udf), int'(tbl[i].udf));
`ifndef FIFO_FWFT_EN
      cmp($sformatf("vec%0d_valid", i), int'(o4_valid), int'(tbl[i].v));
      cmp($sformatf("vec%0d_rdata", i), int'(o4_rdata), int'(tbl[i].rdat));
`endif
    end

    // Wrap-around: pointers cycle several times through both depths.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
      cmp("wrap_push_cnt4", int'(o4_count), 1);
      cmp("wrap_push_cnt3", int'(o3_count), 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cmp("wrap_pop_cnt4", int'(o4_count), 0);
      cmp("wrap_pop_cnt3", int'(o3_count), 0);
      cmp("wrap_err", int'({o4_ovf, o4_udf, o3_ovf, o3_udf}), 0);
`ifndef FIFO_FWFT_EN
      cmp("wrap_data4", int'(o4_rdata), 32'hA0 + i);
      cmp("wrap_data3", int'(o3_rdata), 32'hA0 + i);
      cmp("wrap_valid", int'({o4_valid, o3_valid}), 3);
`endif
    end

    // Single push into an empty FIFO, then a pop.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
    cmp("fwft_show_valid", int'(o4_valid), 1);
    cmp("fwft_show_data", int'(o4_rdata), 32'hC3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("fwft_pop_valid", int'(o4_valid), 0);
`else
    cmp("reg_nopop_valid", int'(o4_valid), 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("reg_pop_valid", int'(o4_valid), 1);
    cmp("reg_pop_data", int'(o4_rdata), 32'hC3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cmp("reg_pulse_end", int'(o4_valid), 0);
    cmp("reg_hold_data", int'(o4_rdata), 32'hC3);
`endif

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 5, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next-generation buffer for the 8-bit 4-entry FIFO in the verification suite. It generalises data width and depth (including non-power-of-two depths) and adds an occupancy count, programmable almost-full/almost-empty flags, guarded push/pop and sticky overflow/underflow error flags. An optional first-word-fall-through read mode is selected at compile time. It is the drop-in buffer for single-clock producer/consumer paths and the next DUT for equivalence checking against a golden model.

## Interface
- DATA_W, 8: data width in bits, ≥1.
- DEPTH, 4: number of entries, ≥2; need not be a power of two.
- AFULL_THRESH, DEPTH-1: `out_almost_full` asserts when count ≥ this value; 1 ≤ AFULL_THRESH ≤ DEPTH.
- AEMPTY_THRESH, 1: `out_almost_empty` asserts when count ≤ this value; 0 ≤ AEMPTY_THRESH < AFULL_THRESH.
- CNT_W (localparam): $clog2(DEPTH+1).
- PTR_W (localparam): $clog2(DEPTH).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_write_ctrl  in  1  push request.
- in_write_data  in  DATA_W  push data.
- in_read_ctrl  in  1  pop request.
- in_clear_err  in  1  clears the sticky error flags.
- out_read_data  out  DATA_W  read data; see Operation for each mode.
- out_read_valid  out  1  `out_read_data` holds valid popped (or head) data.
- out_count  out  CNT_W  current occupancy, 0..DEPTH.
- out_is_full  out  1  count == DEPTH.
- out_is_empty  out  1  count == 0.
- out_almost_full  out  1  count ≥ AFULL_THRESH.
- out_almost_empty  out  1  count ≤ AEMPTY_THRESH.
- out_overflow  out  1  sticky: a push was rejected.
- out_underflow  out  1  sticky: a pop was rejected.

## Operation
Accept conditions:
- A pop is accepted (rd_acc) when `in_read_ctrl` is high and the FIFO is not empty.
- A push is accepted (wr_acc) when `in_write_ctrl` is high and either the FIFO is not full or rd_acc is high in the same cycle. A push and a pop on a full FIFO are both taken.
- A push to an empty FIFO is never bypassed to the read side in the same cycle. A push and a pop on an empty FIFO: the push is accepted, the pop is rejected.

Pointers and memory:
- write_ptr and read_ptr are PTR_W bits. Each increments by 1 on its accept and wraps from DEPTH-1 to 0; a plain binary rollover is not acceptable when DEPTH is not a power of two.
- The memory array is written on wr_acc at write_ptr. The memory has no reset.

Count:
- count_next = count + wr_acc − rd_acc.
- Full, empty, almost-full and almost-empty are registered and computed from count_next, so they always agree with `out_count`.

Errors:
- `out_overflow` sets when `in_write_ctrl` is high and wr_acc is low.
- `out_underflow` sets when `in_read_ctrl` is high and rd_acc is low.
- Both flags stay set until `in_clear_err` or `rst`. If a new error occurs in the same cycle as `in_clear_err`, the flag stays set.
- A rejected request changes no pointer, count or data.

Reset:
- `rst` returns everything to the reset state at the next edge, including mid-burst; stored data is discarded.
- Reset values:
  - `out_count` = 0
  - `out_is_empty` = 1
  - `out_is_full` = 0
  - `out_almost_empty` = 1
  - `out_almost_full` = 0
  - `out_read_data` = 0
  - `out_read_valid` = 0
  - `out_overflow` = 0
  - `out_underflow` = 0
  - both pointers = 0

## Timing
- Push to pop visibility: data pushed at edge N can be popped by a request sampled at edge N+1.
- Flag and count latency: updated at the same edge as the accepted operation.
- Registered read mode (default):
  - On rd_acc at edge N, `out_read_data` loads mem[read_ptr] and `out_read_valid` is high for exactly the cycle after edge N.
  - `out_read_data` holds its value until the next accepted pop.
  - Back-to-back pops give one word per cycle.
- No combinational path from any input to any output in the default mode.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - `out_read_data` = mem[read_ptr] combinationally; `out_read_valid` = !`out_is_empty`.
  - A pop acknowledges the word currently shown; the next word appears after the edge.
  - Latency from push to `out_read_valid`: 1 cycle.
- FIFO_FWFT_EN undefined: registered read mode as described under Timing.

## Test plan
All scenarios use DATA_W=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1, registered read mode unless stated.
- Fill then drain: push 0x11, 0x22, 0x33, 0x44.
  - `out_almost_full` rises with count 3; `out_is_full` rises with count 4.
  - Four pops return 0x11..0x44 in order, each with a one-cycle `out_read_valid` pulse.
  - `out_is_empty` rises after the fourth pop.
- Overflow: at full, push 0x55 alone.
  - Push is rejected; `out_overflow` goes to 1 and stays high.
  - `out_count` stays 4; a later drain returns no 0x55.
  - Assert `in_clear_err` → `out_overflow` = 0.
- Simultaneous operations:
  - At full, push 0x66 with a pop: 0x11 is read, count stays 4, 0x66 is the last word out.
  - At empty, push 0x77 with a pop: `out_underflow` = 1, count = 1.
- Wrap-around: 10 interleaved single push/pop pairs (0xA0..0xA9).
  - Data returns in order, count toggles 0↔1, no error flags.
  - Repeat with DEPTH=3 and check the same.
- Reset mid-operation: with 3 entries held, assert `rst` for 1 cycle.
  - All outputs return to their reset values.
  - A following push 0x5A then pop returns 0x5A.
- FWFT build (FIFO_FWFT_EN defined): push 0xC3 into an empty FIFO.
  - The next cycle shows `out_read_valid` = 1 and `out_read_data` = 0xC3 with no pop issued.
  - A pop clears `out_read_valid`.
